// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: command record and read-return tag.
// Struct field widths follow the default build widths below.
package mem_arb_pkg;

  localparam int unsigned N_CLIENTS_DEF = 4;
  localparam int unsigned ADDR_W_DEF    = 32;
  localparam int unsigned DATA_W_DEF    = 32;
  localparam int unsigned ID_W          = $clog2(N_CLIENTS_DEF);

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
    logic                  we;
  } mem_cmd_t;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } rd_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, search starts after the last winner.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

  localparam int unsigned PtrW = $clog2(N);

  logic [PtrW-1:0] ptr_q;
  logic [PtrW-1:0] winner;
  logic [PtrW-1:0] idx;
  logic            found;

  always_comb begin
    grant  = '0;
    winner = ptr_q;
    idx    = '0;
    found  = 1'b0;
    for (int unsigned off = 1; off <= N; off++) begin
      idx = PtrW'((32'(ptr_q) + off) % N);
      // No grants while in reset so no handshake is silently dropped.
      if (!found && !reset && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        winner     = idx;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q <= PtrW'(N - 1);
    end else if (found) begin
      ptr_q <= winner;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between N_CLIENTS requesters with round-robin
// arbitration, a registered command stage and tagged, in-order read returns.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned N_CLIENTS  = N_CLIENTS_DEF,
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [N_CLIENTS-1:0]        req_valid,
  input  logic [N_CLIENTS-1:0]        req_we,
  input  logic [N_CLIENTS*ADDR_W-1:0] req_addr,
  input  logic [N_CLIENTS*DATA_W-1:0] req_wdata,
  output logic [N_CLIENTS-1:0]        req_ready,
  output logic [N_CLIENTS-1:0]        rsp_valid,
  output logic [DATA_W-1:0]           rsp_data,
  output logic [ADDR_W-1:0]           mem_address,
  output logic [DATA_W-1:0]           mem_write_data,
  output logic                        mem_write_en,
  output logic                        mem_read_en,
  input  logic [DATA_W-1:0]           mem_read_data
);

  logic [N_CLIENTS-1:0] grant;
  mem_cmd_t             win_cmd;
  logic [ID_W-1:0]      win_id;

  mem_cmd_t             cmd_q;
  logic                 cmd_valid_q;
  logic [ID_W-1:0]      id_q;
  rd_tag_t              tag_q [RD_LATENCY];
  logic [N_CLIENTS-1:0] rsp_valid_q;
  logic [DATA_W-1:0]    rsp_data_q;

  rr_arbiter #(
    .N (N_CLIENTS)
  ) u_rr_arbiter (
    .clock (clock),
    .reset (reset),
    .req   (req_valid),
    .grant (grant)
  );

  assign req_ready = grant;

  always_comb begin
    win_cmd = '0;
    win_id  = '0;
    for (int unsigned i = 0; i < N_CLIENTS; i++) begin
      if (grant[i]) begin
        win_cmd.addr  = req_addr[i*ADDR_W +: ADDR_W];
        win_cmd.wdata = req_wdata[i*DATA_W +: DATA_W];
        win_cmd.we    = req_we[i];
        win_id        = ID_W'(i);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
      id_q        <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      for (int unsigned i = 0; i < RD_LATENCY; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      cmd_valid_q <= |grant;
      // Address and data only move on a handshake; idle cycles keep the last command.
      if (|grant) begin
        cmd_q <= win_cmd;
        id_q  <= win_id;
      end
      tag_q[0] <= '{valid: mem_read_en, id: id_q};
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
      rsp_valid_q <= tag_q[RD_LATENCY-1].valid ?
                     (N_CLIENTS'(1) << tag_q[RD_LATENCY-1].id) : '0;
      if (tag_q[RD_LATENCY-1].valid) begin
        rsp_data_q <= mem_read_data;
      end
    end
  end

  assign mem_address    = cmd_q.addr;
  assign mem_write_data = cmd_q.wdata;
  assign mem_write_en   = cmd_valid_q & cmd_q.we;
  assign mem_read_en    = cmd_valid_q & ~cmd_q.we;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_data       = rsp_data_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: two arbiter builds (read latency 1 and 3) share stimulus, each with
// its own behavioural memory, checked against hand-computed expectations.
module tb_mem_port_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req_valid, req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;

  logic [N-1:0]  a_ready, a_rsp, b_ready, b_rsp;
  logic [DW-1:0] a_rdata_rsp, b_rdata_rsp, a_wdata, b_wdata, a_mrdata, b_mrdata;
  logic [AW-1:0] a_addr, b_addr;
  logic          a_wen, a_ren, b_wen, b_ren;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  mem_port_arbiter #(.N_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(1)) dut (
    .clock (clock), .reset (reset),
    .req_valid (req_valid), .req_we (req_we), .req_addr (req_addr), .req_wdata (req_wdata),
    .req_ready (a_ready), .rsp_valid (a_rsp), .rsp_data (a_rdata_rsp),
    .mem_address (a_addr), .mem_write_data (a_wdata), .mem_write_en (a_wen),
    .mem_read_en (a_ren), .mem_read_data (a_mrdata)
  );

  mem_port_arbiter #(.N_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(3)) dut3 (
    .clock (clock), .reset (reset),
    .req_valid (req_valid), .req_we (req_we), .req_addr (req_addr), .req_wdata (req_wdata),
    .req_ready (b_ready), .rsp_valid (b_rsp), .rsp_data (b_rdata_rsp),
    .mem_address (b_addr), .mem_write_data (b_wdata), .mem_write_en (b_wen),
    .mem_read_en (b_ren), .mem_read_data (b_mrdata)
  );

  // Behavioural memories with 1- and 3-cycle read latency.
  logic [DW-1:0] mem_a [256];
  logic [DW-1:0] mem_b [256];
  logic [DW-1:0] pipe_a;
  logic [DW-1:0] pipe_b [3];

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    pipe_a = '0;
    for (int i = 0; i < 3; i++) pipe_b[i] = '0;
  end

  always @(posedge clock) begin
    if (a_wen) mem_a[a_addr[7:0]] <= a_wdata;
    if (a_ren) pipe_a <= mem_a[a_addr[7:0]];
    if (b_wen) mem_b[b_addr[7:0]] <= b_wdata;
    if (b_ren) pipe_b[0] <= mem_b[b_addr[7:0]];
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end

  assign a_mrdata = pipe_a;
  assign b_mrdata = pipe_b[2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_reqs();
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  task automatic set_req(input int c, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data);
    req_valid[c]           = 1'b1;
    req_we[c]              = we;
    req_addr[c*AW +: AW]   = addr;
    req_wdata[c*DW +: DW]  = data;
  endtask

  task automatic step();
    @(negedge clock);
    clear_reqs();
  endtask

  task automatic set_all_reads();
    for (int c = 0; c < 4; c++) set_req(c, 1'b0, AW'(c), '0);
  endtask

  logic [3:0] exp_ready [5];
  logic [3:0] ea, eb;
  logic [31:0] da, db;

  initial begin
    exp_ready[0] = 4'b0001;
    exp_ready[1] = 4'b0010;
    exp_ready[2] = 4'b0100;
    exp_ready[3] = 4'b1000;
    exp_ready[4] = 4'b0001;
    clear_reqs();
    set_all_reads();

    // 1. Reset state, then round-robin rotation from client 0.
    step(); set_all_reads(); #1;
    check("rst_ready", 64'(a_ready), 64'(0));
    check("rst_wen", 64'(a_wen), 64'(0));
    check("rst_ren", 64'(a_ren), 64'(0));
    check("rst_rsp", 64'(a_rsp), 64'(0));
    check("rst_addr", 64'(a_addr), 64'(0));
    check("rst_rsp3", 64'(b_rsp), 64'(0));
    for (int k = 0; k < 5; k++) begin
      step();
      if (k == 0) reset = 1'b0;
      set_all_reads();
      #1;
      check("rr_ready", 64'(a_ready), 64'(exp_ready[k]));
      check("rr_ready3", 64'(b_ready), 64'(exp_ready[k]));
      if (k == 1) begin
        check("rr_ren", 64'(a_ren), 64'(1));
        check("rr_wen", 64'(a_wen), 64'(0));
        check("rr_addr", 64'(a_addr), 64'(0));
      end
    end
    repeat (5) step();

    // 2. Client 2 writes 0x10, client 1 reads it back.
    step(); set_req(2, 1'b1, 32'h10, 32'hDEADBEEF); #1;
    check("raw_wr_ready", 64'(a_ready), 64'(4'b0100));
    step(); set_req(1, 1'b0, 32'h10, '0); #1;
    check("raw_rd_ready", 64'(a_ready), 64'(4'b0010));
    check("raw_wen", 64'(a_wen), 64'(1));
    check("raw_ren0", 64'(a_ren), 64'(0));
    check("raw_waddr", 64'(a_addr), 64'(32'h10));
    check("raw_wdata", 64'(a_wdata), 64'(32'hDEADBEEF));
    step(); #1;
    check("raw_ren", 64'(a_ren), 64'(1));
    check("raw_wen0", 64'(a_wen), 64'(0));
    check("raw_raddr", 64'(a_addr), 64'(32'h10));
    step(); #1;
    check("raw_rsp_early", 64'(a_rsp), 64'(0));
    step(); #1;
    check("raw_rsp", 64'(a_rsp), 64'(4'b0010));
    check("raw_data", 64'(a_rdata_rsp), 64'(32'hDEADBEEF));
    step(); #1;
    check("raw_rsp_end", 64'(a_rsp), 64'(0));
    check("raw_data_hold", 64'(a_rdata_rsp), 64'(32'hDEADBEEF));

    // 3. Client 3 alone: four writes, then four back-to-back reads.
    for (int k = 0; k < 4; k++) begin
      step(); set_req(3, 1'b1, AW'(k), 32'hA0 + 32'(k)); #1;
      check("b2b_wr_ready", 64'(a_ready), 64'(4'b1000));
    end
    for (int k = 0; k < 8; k++) begin
      step();
      if (k < 4) set_req(3, 1'b0, AW'(k), '0);
      #1;
      if (k < 4) check("b2b_rd_ready", 64'(a_ready), 64'(4'b1000));
      if (k >= 3 && k < 7) begin
        check("b2b_rsp", 64'(a_rsp), 64'(4'b1000));
        check("b2b_data", 64'(a_rdata_rsp), 64'(32'hA0 + 32'(k - 3)));
      end else begin
        check("b2b_rsp_idle", 64'(a_rsp), 64'(0));
      end
    end

    // 4. Pointer at 0, clients 0 and 2 contend; idle cycles hold the pointer.
    step(); set_req(0, 1'b1, 32'h40, 32'h1); #1;
    check("ptr_setup", 64'(a_ready), 64'(4'b0001));
    step(); set_req(0, 1'b1, 32'h40, 32'h1); set_req(2, 1'b1, 32'h41, 32'h2); #1;
    check("ptr_c2", 64'(a_ready), 64'(4'b0100));
    step(); set_req(0, 1'b1, 32'h40, 32'h1); set_req(2, 1'b1, 32'h41, 32'h2); #1;
    check("ptr_c0", 64'(a_ready), 64'(4'b0001));
    step(); #1;
    check("ptr_idle_ready", 64'(a_ready), 64'(0));
    step(); step();
    step(); set_req(0, 1'b1, 32'h40, 32'h1); set_req(2, 1'b1, 32'h41, 32'h2); #1;
    check("ptr_hold", 64'(a_ready), 64'(4'b0100));
    step(); step();

    // 5. Reset the cycle after a read grant: the read is never returned.
    step(); set_req(1, 1'b0, 32'h10, '0); #1;
    check("mid_rst_grant", 64'(a_ready), 64'(4'b0010));
    step(); reset = 1'b1; set_req(1, 1'b0, 32'h10, '0); #1;
    check("mid_rst_ready", 64'(a_ready), 64'(0));
    check("mid_rst_ren_live", 64'(a_ren), 64'(1));
    step(); #1;
    check("mid_rst_ren", 64'(a_ren), 64'(0));
    check("mid_rst_wen", 64'(a_wen), 64'(0));
    check("mid_rst_addr", 64'(a_addr), 64'(0));
    check("mid_rst_wdata", 64'(a_wdata), 64'(0));
    check("mid_rst_rsp", 64'(a_rsp), 64'(0));
    check("mid_rst_data", 64'(a_rdata_rsp), 64'(0));
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step(); #1;
      check("mid_rst_stale", 64'(a_rsp), 64'(0));
      check("mid_rst_stale3", 64'(b_rsp), 64'(0));
    end

    // 6. Mixed write/read interleave; latency 3 and latency 1 builds side by side.
    for (int k = 0; k < 11; k++) begin
      step();
      case (k)
        0: set_req(0, 1'b1, 32'h20, 32'h11);
        1: set_req(1, 1'b0, 32'h20, '0);
        2: set_req(2, 1'b1, 32'h21, 32'h22);
        3: set_req(3, 1'b0, 32'h21, '0);
        4: set_req(0, 1'b0, 32'h10, '0);
        default: ;
      endcase
      #1;
      if (k < 5) check("mix_ready3", 64'(b_ready), 64'(4'b0001 << (k % 4)));
      ea = 4'b0000; da = 32'h0;
      eb = 4'b0000; db = 32'h0;
      case (k)
        4: begin ea = 4'b0010; da = 32'h11;       end
        6: begin ea = 4'b1000; da = 32'h22;       eb = 4'b0010; db = 32'h11; end
        7: begin ea = 4'b0001; da = 32'hDEADBEEF; end
        8: begin                                  eb = 4'b1000; db = 32'h22; end
        9: begin                                  eb = 4'b0001; db = 32'hDEADBEEF; end
        default: ;
      endcase
      check("mix_rsp", 64'(a_rsp), 64'(ea));
      check("mix_rsp3", 64'(b_rsp), 64'(eb));
      if (ea != 4'b0000) check("mix_data", 64'(a_rdata_rsp), 64'(da));
      if (eb != 4'b0000) check("mix_data3", 64'(b_rdata_rsp), 64'(db));
      check("mix_excl", 64'(a_wen & a_ren), 64'(0));
      check("mix_excl3", 64'(b_wen & b_ren), 64'(0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
